// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch / PC control block.
package fetch_pkg;

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/fetch_pc_ctrl_next_pc_sel.sv
// Next-PC mux: sequential PC, redirect target, or trap vector on a misaligned redirect.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic        jump_en,
    input  logic [31:0] target_addr,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic redirect;

    assign redirect   = br_taken | jump_en;
    assign misaligned = redirect & (target_addr[1:0] != 2'b00);

    always_comb begin
        next_pc = pc + 32'd4;
        if (misaligned)
            next_pc = TRAP_VEC;
        else if (redirect)
            next_pc = target_addr;
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Program counter owner and single-outstanding IMEM fetch FSM with timeout retry.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC      = DEF_TRAP_VEC,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        jump_en,
    input  logic [31:0] target_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        trap_misaligned,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FETCH_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

    fetch_state_t  state;
    logic [CW-1:0] cnt;
    logic [31:0]   next_pc;
    logic          misaligned;

    next_pc_sel #(.TRAP_VEC(TRAP_VEC)) u_next_pc_sel (
        .pc          (pc),
        .br_taken    (br_taken),
        .jump_en     (jump_en),
        .target_addr (target_addr),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // imem_req/instr_valid are registered against the state being entered,
    // so they are high exactly while the FSM sits in S_REQ/S_HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_BOOT;
            pc              <= RESET_PC;
            imem_req        <= 1'b0;
            instr_valid     <= 1'b0;
            instr           <= NOP_INSTR;
            trap_misaligned <= 1'b0;
            fetch_fault     <= 1'b0;
            cnt             <= '0;
        end else begin
            trap_misaligned <= 1'b0;
            fetch_fault     <= 1'b0;
            imem_req        <= 1'b0;
            case (state)
                S_BOOT: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        fetch_fault <= 1'b1;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc              <= next_pc;
                        trap_misaligned <= misaligned;
                        instr_valid     <= 1'b0;
                        imem_req        <= 1'b1;
                        state           <= S_REQ;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, jump_en, imem_rvalid;
    logic [31:0] target_addr, imem_rdata;
    logic        imem_req, instr_valid, trap_misaligned, fetch_fault;
    logic [31:0] imem_addr, instr, pc, pc_plus4;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_pc_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_taken        (br_taken),
        .jump_en         (jump_en),
        .target_addr     (target_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .trap_misaligned (trap_misaligned),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the request, answers one cycle later, checks the presented instr.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (!imem_req && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, data);
        chk({tag, "_pc"}, pc, addr);
    endtask

    task automatic retire(input string tag, input logic br, input logic jmp,
                          input logic [31:0] tgt, input logic [31:0] exp_next);
        stall       = 1'b0;
        br_taken    = br;
        jump_en     = jmp;
        target_addr = tgt;
        tick();
        stall       = 1'b1;
        br_taken    = 1'b0;
        jump_en     = 1'b0;
        target_addr = 32'h0;
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_next"}, imem_addr, exp_next);
        chk({tag, "_vld0"}, {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b1; br_taken = 1'b0; jump_en = 1'b0;
        target_addr = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_vld",   {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_trap",  {31'd0, trap_misaligned}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // 1: boot fetch, 3-cycle latency from release
        rst = 1'b0;
        tick();
        chk("t1_req_c1", {31'd0, imem_req}, 32'd1);
        do_fetch("t1", 32'h0, 32'h0050_0093);

        // 2: redirect selection
        retire("t2_j10", 1'b0, 1'b1, 32'h10, 32'h10);
        do_fetch("t2_f10", 32'h10, 32'h1111_0000);
        retire("t2_br", 1'b1, 1'b0, 32'h40, 32'h40);
        do_fetch("t2_f40", 32'h40, 32'h2222_0000);
        retire("t2_j10b", 1'b0, 1'b1, 32'h10, 32'h10);
        do_fetch("t2_f10b", 32'h10, 32'h3333_0000);
        chk("t2_pcp4", pc_plus4, 32'h14);
        retire("t2_nobr", 1'b0, 1'b0, 32'h40, 32'h14);
        do_fetch("t2_f14", 32'h14, 32'h4444_0000);
        retire("t2_j10c", 1'b0, 1'b1, 32'h10, 32'h10);
        do_fetch("t2_f10c", 32'h10, 32'h5555_0000);
        retire("t2_both", 1'b1, 1'b1, 32'h40, 32'h40);
        do_fetch("t2_f40b", 32'h40, 32'h6666_0000);

        // 3: stall holds everything; only the first !stall cycle's br_taken counts
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1;
            br_taken = (i % 2 == 0);
            target_addr = 32'h80;
            tick();
            chk("t3_vld",   {31'd0, instr_valid}, 32'd1);
            chk("t3_pc",    pc, 32'h40);
            chk("t3_instr", instr, 32'h6666_0000);
            chk("t3_noreq", {31'd0, imem_req}, 32'd0);
        end
        retire("t3_rel", 1'b0, 1'b0, 32'h80, 32'h44);
        do_fetch("t3_f44", 32'h44, 32'h7777_0000);

        // 4: misaligned redirect traps
        retire("t4", 1'b1, 1'b0, 32'h42, 32'h100);
        chk("t4_trap1", {31'd0, trap_misaligned}, 32'd1);
        tick();
        chk("t4_trap0", {31'd0, trap_misaligned}, 32'd0);

        // 5: timeout: now 1 cycle into S_WAIT, fault on the 16th S_WAIT edge
        for (int i = 0; i < 15; i++) tick();
        chk("t5_nofault", {31'd0, fetch_fault}, 32'd0);
        chk("t5_noreq",   {31'd0, imem_req}, 32'd0);
        tick();
        chk("t5_fault", {31'd0, fetch_fault}, 32'd1);
        chk("t5_rereq", {31'd0, imem_req}, 32'd1);
        chk("t5_addr",  imem_addr, 32'h100);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0000;
        tick();
        imem_rvalid = 1'b0;
        chk("t5_fault0", {31'd0, fetch_fault}, 32'd0);
        tick();
        chk("t5_late_drop", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8888_0000;
        tick();
        imem_rvalid = 1'b0;
        chk("t5_vld",   {31'd0, instr_valid}, 32'd1);
        chk("t5_instr", instr, 32'h8888_0000);
        chk("t5_pc",    pc, 32'h100);

        // 6: reset mid-S_WAIT, stale rvalid in S_BOOT, then PC wrap
        retire("t6_seq", 1'b0, 1'b0, 32'h0, 32'h104);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_pc",    pc, 32'h0);
        chk("t6_rst_vld",   {31'd0, instr_valid}, 32'd0);
        chk("t6_rst_instr", instr, 32'h0000_0013);
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD1_0000;
        tick();
        imem_rvalid = 1'b0;
        chk("t6_stale_vld", {31'd0, instr_valid}, 32'd0);
        do_fetch("t6_f0", 32'h0, 32'h9999_0000);
        retire("t6_jtop", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        do_fetch("t6_ftop", 32'hFFFF_FFFC, 32'hAAAA_0000);
        chk("t6_pcp4_wrap", pc_plus4, 32'h0);
        retire("t6_wrap", 1'b0, 1'b0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
